// File: rtl/sd_vc_pkg.sv
// Shared definitions for the sd2vc / vc2sd credit link.
// Credit counter sizing, the depth-matching rule and the per-cycle credit operation.
package sd_vc_pkg;

    typedef enum logic [1:0] {
        CR_HOLD   = 2'd0,
        CR_TAKE   = 2'd1,
        CR_RETURN = 2'd2
    } cr_op_e;

    function automatic int cred_width(input int credits);
        return $clog2(credits + 1);
    endfunction

    // The transmitter's credit pool must match the receiver FIFO depth exactly.
    function automatic bit depth_matches(input int credits, input int fifo_depth);
        return credits == fifo_depth;
    endfunction

endpackage

// File: rtl/vc_credit_counter.sv
// Saturating up/down credit counter with an optional credit-return register
// and a sticky overflow flag for returns that arrive while the pool is full.
module vc_credit_counter
    import sd_vc_pkg::*;
#(
    parameter int credits = 16,
    parameter int csz     = cred_width(credits),
    parameter bit regcr   = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           take,
    input  logic           p_cr,
    output logic [csz-1:0] cred_cnt,
    output logic           cr_overflow
);

    localparam logic [csz-1:0] full = csz'(credits);

    logic   cr_q;
    logic   cr_in;
    cr_op_e op;

    assign cr_in = regcr ? cr_q : p_cr;

    // A take and a return in the same cycle cancel, so neither boundary is touched.
    always_comb begin
        op = CR_HOLD;
        if (take && !cr_in) begin
            op = CR_TAKE;
        end else if (!take && cr_in) begin
            op = CR_RETURN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cred_cnt    <= full;
            cr_overflow <= 1'b0;
            cr_q        <= 1'b0;
        end else begin
            cr_q <= p_cr;
            case (op)
                CR_TAKE: begin
                    if (cred_cnt != '0) begin
                        cred_cnt <= cred_cnt - csz'(1);
                    end
                end
                CR_RETURN: begin
                    if (cred_cnt == full) begin
                        cr_overflow <= 1'b1;
                    end else begin
                        cred_cnt <= cred_cnt + csz'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/sd2vc.sv
// srdy/drdy to valid/credit converter: accepts a producer beat whenever a
// credit is available and forwards it as a registered one-cycle p_vld pulse.
module sd2vc
    import sd_vc_pkg::*;
#(
    parameter int width   = 8,
    parameter int credits = 16,
    parameter int csz     = cred_width(credits),
    parameter bit regcr   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic [width-1:0] c_data,
    output logic             p_vld,
    output logic [width-1:0] p_data,
    input  logic             p_cr,
    output logic [csz-1:0]   cred_avail,
    output logic             idle,
    output logic             cr_overflow
);

    logic           xfer;
    logic [csz-1:0] cred_cnt;

    assign c_drdy     = (cred_cnt != '0);
    assign xfer       = c_srdy && c_drdy;
    assign cred_avail = cred_cnt;
    assign idle       = (cred_cnt == csz'(credits)) && !p_vld;

    vc_credit_counter #(
        .credits (credits),
        .csz     (csz),
        .regcr   (regcr)
    ) u_credit (
        .clk         (clk),
        .reset       (reset),
        .take        (xfer),
        .p_cr        (p_cr),
        .cred_cnt    (cred_cnt),
        .cr_overflow (cr_overflow)
    );

    // p_data keeps the last beat between pulses so the link sees stable data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_vld  <= 1'b0;
            p_data <= '0;
        end else begin
            p_vld <= xfer;
            if (xfer) begin
                p_data <= c_data;
            end
        end
    end

endmodule

// File: tb/tb_sd2vc.sv
// Self-checking bench for sd2vc: one instance without and one with the
// credit-return register, both driven by the same producer and credit stream.
module tb_sd2vc;

    localparam int CREDITS = 4;
    localparam int CSZ     = 3;

    logic           clk;
    logic           reset;
    logic           c_srdy;
    logic [7:0]     c_data;
    logic           p_cr;

    logic           drdy_o  [2];
    logic           vld_o   [2];
    logic [7:0]     data_o  [2];
    logic [CSZ-1:0] cav_o   [2];
    logic           idle_o  [2];
    logic           ovf_o   [2];

    int             m_cnt   [2];
    bit             m_pv    [2];
    logic [7:0]     m_pd    [2];
    bit             m_ovf   [2];
    bit             m_crd;

    int errors = 0;
    int checks = 0;

    sd2vc #(.width(8), .credits(CREDITS), .csz(CSZ), .regcr(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(drdy_o[0]),
        .c_data(c_data), .p_vld(vld_o[0]), .p_data(data_o[0]), .p_cr(p_cr),
        .cred_avail(cav_o[0]), .idle(idle_o[0]), .cr_overflow(ovf_o[0])
    );

    sd2vc #(.width(8), .credits(CREDITS), .csz(CSZ), .regcr(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(drdy_o[1]),
        .c_data(c_data), .p_vld(vld_o[1]), .p_data(data_o[1]), .p_cr(p_cr),
        .cred_avail(cav_o[1]), .idle(idle_o[1]), .cr_overflow(ovf_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a credit pool, a one-deep return delay for the registered variant.
    function automatic bit m_take(input int cnt);
        return c_srdy && (cnt > 0);
    endfunction

    function automatic bit m_cr(input int k);
        return (k == 0) ? p_cr : m_crd;
    endfunction

    function automatic int m_next(input int cnt, input bit x, input bit cr);
        if (x && !cr) return cnt - 1;
        if (!x && cr && cnt < CREDITS) return cnt + 1;
        return cnt;
    endfunction

    function automatic logic [14:0] m_expect(input int k);
        return {m_cnt[k] != 0, m_pv[k], m_pd[k], CSZ'(m_cnt[k]),
                (m_cnt[k] == CREDITS) && !m_pv[k], m_ovf[k]};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] <= CREDITS;
                m_pv[k]  <= 1'b0;
                m_pd[k]  <= 8'h00;
                m_ovf[k] <= 1'b0;
            end
            m_crd <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_pv[k]  <= m_take(m_cnt[k]);
                if (m_take(m_cnt[k])) m_pd[k] <= c_data;
                m_cnt[k] <= m_next(m_cnt[k], m_take(m_cnt[k]), m_cr(k));
                if (!m_take(m_cnt[k]) && m_cr(k) && m_cnt[k] == CREDITS) m_ovf[k] <= 1'b1;
            end
            m_crd <= p_cr;
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset  = 1'b0;
        c_srdy = 1'b0;
        c_data = 8'h00;
        p_cr   = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({drdy_o[k], vld_o[k], cav_o[k], idle_o[k], ovf_o[k]} !== {1'b1, 1'b0, 3'd4, 1'b1, 1'b0}) begin
                errors++;
                $display("[TB] FAIL reset dut%0d: drdy/vld/cav/idle/ovf got %b %b %0d %b %b expected 1 0 4 1 0",
                         k, drdy_o[k], vld_o[k], cav_o[k], idle_o[k], ovf_o[k]);
            end
        end
    endtask

    task automatic test_burst;
        int idx = 0;
        bit acc;
        c_srdy = 1'b1;
        c_data = 8'hA0;
        for (int i = 1; i <= 6; i++) begin
            acc = c_srdy && drdy_o[0];
            tick();
            if (acc) idx++;
            c_data = 8'hA0 + 8'(idx);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({drdy_o[k], vld_o[k], data_o[k], cav_o[k], idle_o[k], ovf_o[k]} !== m_expect(k)) begin
                    errors++;
                    $display("[TB] FAIL burst_model dut%0d cyc%0d: got %h expected %h", k, i,
                             {drdy_o[k], vld_o[k], data_o[k], cav_o[k], idle_o[k], ovf_o[k]}, m_expect(k));
                end
                checks++;
                if (vld_o[k] !== (i <= 4) || (i <= 4 && data_o[k] !== 8'hA0 + 8'(i - 1))) begin
                    errors++;
                    $display("[TB] FAIL burst_beat dut%0d cyc%0d: vld=%b data=%h expected vld=%b data=%h",
                             k, i, vld_o[k], data_o[k], i <= 4, 8'hA0 + 8'(i - 1));
                end
            end
        end
        checks++;
        if (idx !== 4 || cav_o[0] !== 3'd0 || drdy_o[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL burst_end: accepted=%0d cav=%0d drdy=%b expected 4 0 0", idx, cav_o[0], drdy_o[0]);
        end
    endtask

    task automatic test_credit_return;
        int beat_cyc [2] = '{0, 0};
        int beats    [2] = '{0, 0};
        p_cr = 1'b1;
        tick();
        p_cr = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({drdy_o[k], vld_o[k], data_o[k], cav_o[k], idle_o[k], ovf_o[k]} !== m_expect(k)) begin
                    errors++;
                    $display("[TB] FAIL credit_model dut%0d cyc%0d: got %h expected %h", k, i,
                             {drdy_o[k], vld_o[k], data_o[k], cav_o[k], idle_o[k], ovf_o[k]}, m_expect(k));
                end
                if (vld_o[k] === 1'b1) begin
                    beats[k]++;
                    beat_cyc[k] = i;
                end
            end
            tick();
        end
        c_srdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (beats[k] !== 1 || beat_cyc[k] !== 2 + k || cav_o[k] !== 3'd0) begin
                errors++;
                $display("[TB] FAIL credit_return dut%0d: beats=%0d at cyc%0d cav=%0d expected 1 at cyc%0d cav=0",
                         k, beats[k], beat_cyc[k], cav_o[k], 2 + k);
            end
        end
    endtask

    task automatic test_steady;
        int beats = 0;
        p_cr = 1'b1;
        tick();
        tick();
        p_cr = 1'b0;
        tick();
        tick();
        checks++;
        if (cav_o[0] !== 3'd2 || cav_o[1] !== 3'd2) begin
            errors++;
            $display("[TB] FAIL steady_setup: cav=%0d,%0d expected 2,2", cav_o[0], cav_o[1]);
        end
        c_srdy = 1'b1;
        p_cr   = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            c_data = 8'($urandom);
            tick();
            if (vld_o[0] === 1'b1) beats++;
            checks++;
            if (cav_o[0] !== 3'd2) begin
                errors++;
                $display("[TB] FAIL steady_cav cyc%0d: got %0d expected 2", i, cav_o[0]);
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({drdy_o[k], vld_o[k], data_o[k], cav_o[k], idle_o[k], ovf_o[k]} !== m_expect(k)) begin
                    errors++;
                    $display("[TB] FAIL steady_model dut%0d cyc%0d: got %h expected %h", k, i,
                             {drdy_o[k], vld_o[k], data_o[k], cav_o[k], idle_o[k], ovf_o[k]}, m_expect(k));
                end
            end
        end
        c_srdy = 1'b0;
        p_cr   = 1'b0;
        tick();
        tick();
        checks++;
        if (beats !== 10 || ovf_o[0] !== 1'b0 || ovf_o[1] !== 1'b0 || cav_o[1] !== 3'd2) begin
            errors++;
            $display("[TB] FAIL steady_end: beats=%0d ovf=%b,%b cav1=%0d expected 10 0,0 2",
                     beats, ovf_o[0], ovf_o[1], cav_o[1]);
        end
    endtask

    task automatic test_overflow;
        p_cr = 1'b1;
        tick();
        tick();
        p_cr = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (cav_o[k] !== 3'd4 || idle_o[k] !== 1'b1 || ovf_o[k] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL overflow_full dut%0d: cav=%0d idle=%b ovf=%b expected 4 1 0",
                         k, cav_o[k], idle_o[k], ovf_o[k]);
            end
        end
        p_cr = 1'b1;
        tick();
        p_cr = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (cav_o[k] !== 3'd4 || ovf_o[k] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL overflow_sticky dut%0d: cav=%0d ovf=%b expected 4 1", k, cav_o[k], ovf_o[k]);
            end
        end
    endtask

    task automatic test_async_reset;
        c_srdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c_data = 8'($urandom);
            tick();
        end
        checks++;
        if (cav_o[0] !== 3'd1 || vld_o[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_setup: cav=%0d vld=%b expected 1 1", cav_o[0], vld_o[0]);
        end
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (vld_o[k] !== 1'b0 || cav_o[k] !== 3'd4 || ovf_o[k] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL async_reset dut%0d: vld=%b cav=%0d ovf=%b expected 0 4 0",
                         k, vld_o[k], cav_o[k], ovf_o[k]);
            end
        end
        tick();
        reset  = 1'b1;
        c_data = 8'h5A;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (vld_o[k] !== 1'b1 || data_o[k] !== 8'h5A || cav_o[k] !== 3'd3) begin
                errors++;
                $display("[TB] FAIL async_resume dut%0d: vld=%b data=%h cav=%0d expected 1 5a 3",
                         k, vld_o[k], data_o[k], cav_o[k]);
            end
        end
        c_srdy = 1'b0;
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            c_srdy = ($urandom_range(0, 9) < 7);
            p_cr   = (m_cnt[0] < CREDITS) && ($urandom_range(0, 9) < 5);
            c_data = 8'($urandom);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({drdy_o[k], vld_o[k], data_o[k], cav_o[k], idle_o[k], ovf_o[k]} !== m_expect(k)) begin
                    errors++;
                    $display("[TB] FAIL random_model dut%0d cyc%0d: got %h expected %h", k, i,
                             {drdy_o[k], vld_o[k], data_o[k], cav_o[k], idle_o[k], ovf_o[k]}, m_expect(k));
                end
            end
        end
        c_srdy = 1'b0;
        p_cr   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_burst();
        test_credit_return();
        test_steady();
        test_overflow();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd2vc.md
Name: sd2vc

Overview:
- Upstream neighbour of the vc2sd receiver. Converts an srdy/drdy producer stream into a valid/credit link.
- Holds a credit counter preloaded with the receiver FIFO depth. Emits one registered p_vld beat per consumed credit and replenishes on each p_cr pulse.
- Sits at the transmit end of a vc link. Its p_vld/p_data/p_cr connect directly to the c_vld/c_data/c_cr ports of vc2sd.

Parameters:
- width, 8: data width in bits.
- credits, 16: initial and maximum credit count; must equal the downstream FIFO depth.
- csz, $clog2(credits+1): credit counter width.
- regcr, 0: 1 = register p_cr for one cycle before it is counted (adds 1 cycle of return latency).

Ports:
- clk  input  1  clock, all logic rising-edge.
- reset  input  1  asynchronous, active-low reset.
- c_srdy  input  1  producer data valid.
- c_drdy  output  1  block can accept a beat this cycle.
- c_data  input  width  producer data.
- p_vld  output  1  one-cycle valid pulse to the vc link.
- p_data  output  width  data accompanying p_vld.
- p_cr  input  1  credit-return pulse from the receiver, one credit per cycle asserted.
- cred_avail  output  csz  current credit count.
- idle  output  1  cred_avail == credits and p_vld == 0.
- cr_overflow  output  1  sticky error flag.

Behaviour:
- Reset (asynchronous, reset == 0):
  - cred_cnt = credits, p_vld = 0, p_data = 0.
  - cr_overflow = 0, regcr pipeline register = 0.
- Combinational outputs:
  - c_drdy = (cred_cnt != 0); does not depend on c_srdy.
  - cred_avail = cred_cnt.
- Transfer: xfer = c_srdy & c_drdy. On the next rising edge:
  - p_vld = xfer.
  - If xfer, p_data = c_data; otherwise p_data holds its previous value.
- Latency: producer handshake to p_vld is 1 cycle.
- Throughput: 1 beat/cycle while credits remain.
- Credit return: cr_in = p_cr when regcr = 0, or p_cr delayed 1 cycle when regcr = 1.
- Counter update per cycle:
  - xfer & !cr_in: cred_cnt - 1.
  - !xfer & cr_in: cred_cnt + 1.
  - xfer & cr_in: unchanged (net zero, including at cred_cnt == 0 or == credits).
  - neither: unchanged.
- Empty boundary:
  - cred_cnt == 0 forces c_drdy = 0.
  - A p_cr arriving while cred_cnt == 0 makes c_drdy = 1 on the cycle after cr_in is seen.
- Full boundary: cr_in while cred_cnt == credits and !xfer:
  - counter saturates at credits;
  - cr_overflow is set and stays set until reset.
- No arithmetic wrap is permitted. The counter is never decremented below 0, which the c_drdy gating guarantees.
- idle is registered-consistent: computed from cred_cnt and p_vld as they stand after the clock edge.
- Reset asserted mid-operation:
  - all state returns immediately to reset values and any in-flight beat is dropped;
  - the link partner must be reset in the same domain.

Decomposition:
- Shared package sd_vc_pkg holds:
  - the credit width function (clog2 of credits + 1);
  - the sd2vc/vc2sd depth-matching rule.
- One natural sub-module, vc_credit_counter. It contains:
  - the up/down saturating counter;
  - the regcr register;
  - overflow detection.
- sd2vc top contains the handshake gating and the output data register.

Test Plan:
- Reset with credits=4, no traffic: cred_avail=4, c_drdy=1, p_vld=0, idle=1, cr_overflow=0.
- c_srdy held high with data 0xA0..0xA5 and no p_cr: p_vld pulses on 4 consecutive cycles carrying 0xA0..0xA3. Then c_drdy=0 and cred_avail=0, and 0xA4 is held by the producer.
- From cred_avail=0, pulse p_cr once:
  - regcr=0: c_drdy=1 the next cycle, 0xA4 is sent, cred_avail returns to 0.
  - regcr=1: the same sequence occurs one cycle later.
- Steady state with credits=4, cred_avail=2, xfer and p_cr both asserted every cycle for 10 cycles: cred_avail stays 2, 10 p_vld beats, no overflow.
- Idle with cred_avail=4, one extra p_cr pulse: cred_avail stays 4 and cr_overflow=1 remains set until reset is asserted.
- Reset asserted asynchronously mid-burst with cred_avail=1 and p_vld=1: p_vld=0 and cred_avail=4 immediately, without waiting for a clock edge. After release, traffic resumes from a full credit count.
